// File: rtl/alu_operand_stage_pkg.sv
// Shared constants for the ALU operand stage: widths, ALU opcodes, forward-select codes.
// Forwarding is enabled by defining ALU_OPERAND_FWD_EN.
package alu_operand_stage_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_NOR  = 3'b100;
    localparam logic [2:0] ALU_SRL  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_EXM  = 2'd1;
    localparam logic [1:0] FWD_WB   = 2'd2;

endpackage

// File: rtl/alu_fwd_mux.sv
// Picks the freshest value for one source register; EX/MEM beats MEM/WB, x0 is never forwarded.
// Combinational; with ALU_OPERAND_FWD_EN undefined it passes the registered value through.
module alu_fwd_mux
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] i_src_addr,
    input  logic [XLEN-1:0]   i_reg_val,
    input  logic [REG_AW-1:0] i_exm_rd,
    input  logic              i_exm_we,
    input  logic [XLEN-1:0]   i_exm_res,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic              i_wb_we,
    input  logic [XLEN-1:0]   i_wb_data,
    output logic [XLEN-1:0]   o_val
);

`ifdef ALU_OPERAND_FWD_EN
    logic [1:0] w_sel;

    always_comb begin
        w_sel = FWD_NONE;
        if (i_exm_we && (i_exm_rd != '0) && (i_exm_rd == i_src_addr)) begin
            w_sel = FWD_EXM;
        end else if (i_wb_we && (i_wb_rd != '0) && (i_wb_rd == i_src_addr)) begin
            w_sel = FWD_WB;
        end
    end

    always_comb begin
        case (w_sel)
            FWD_EXM: o_val = i_exm_res;
            FWD_WB:  o_val = i_wb_data;
            default: o_val = i_reg_val;
        endcase
    end
`else
    logic w_unused;
    assign w_unused = ^{i_src_addr, i_exm_rd, i_exm_we, i_exm_res, i_wb_rd, i_wb_we, i_wb_data};
    assign o_val    = i_reg_val;
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register feeding the 32-bit ALU; forwarding enabled by ALU_OPERAND_FWD_EN.
// Latency 1 cycle; single entry, in_ready = !out_valid || out_ready, flush overrides capture.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   imm,
    input  logic              alu_src,
    input  logic [2:0]        alu_op,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_we,
    input  logic [XLEN-1:0]   exm_res,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [XLEN-1:0]   A,
    output logic [XLEN-1:0]   B,
    output logic [2:0]        ALU_operation,
    output logic [XLEN-1:0]   store_data,
    output logic [REG_AW-1:0] rd_out,
    output logic              reg_write_out
);

    logic              r_valid;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic              r_alu_src;
    logic [2:0]        r_alu_op;
    logic [REG_AW-1:0] r_rs1_addr;
    logic [REG_AW-1:0] r_rs2_addr;
    logic [REG_AW-1:0] r_rd_addr;
    logic              r_reg_write;

    logic              w_capture;
    logic [XLEN-1:0]   w_rs1_val;
    logic [XLEN-1:0]   w_rs2_val;

    assign in_ready  = !r_valid || out_ready;
    assign w_capture = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_alu_src   <= 1'b0;
            r_alu_op    <= ALU_AND;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rd_addr   <= '0;
            r_reg_write <= 1'b0;
        end else begin
            // Flush only kills the valid bit; stale data is masked by out_valid.
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_capture) begin
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_capture) begin
                r_rs1_data  <= rs1_data;
                r_rs2_data  <= rs2_data;
                r_imm       <= imm;
                r_alu_src   <= alu_src;
                r_alu_op    <= alu_op;
                r_rs1_addr  <= rs1_addr;
                r_rs2_addr  <= rs2_addr;
                r_rd_addr   <= rd_addr;
                r_reg_write <= reg_write;
            end
        end
    end

    alu_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .i_src_addr (r_rs1_addr),
        .i_reg_val  (r_rs1_data),
        .i_exm_rd   (exm_rd),
        .i_exm_we   (exm_we),
        .i_exm_res  (exm_res),
        .i_wb_rd    (wb_rd),
        .i_wb_we    (wb_we),
        .i_wb_data  (wb_data),
        .o_val      (w_rs1_val)
    );

    alu_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .i_src_addr (r_rs2_addr),
        .i_reg_val  (r_rs2_data),
        .i_exm_rd   (exm_rd),
        .i_exm_we   (exm_we),
        .i_exm_res  (exm_res),
        .i_wb_rd    (wb_rd),
        .i_wb_we    (wb_we),
        .i_wb_data  (wb_data),
        .o_val      (w_rs2_val)
    );

    assign out_valid     = r_valid;
    assign A             = w_rs1_val;
    assign B             = r_alu_src ? r_imm : w_rs2_val;
    assign ALU_operation = r_alu_op;
    assign store_data    = w_rs2_val;
    assign rd_out        = r_rd_addr;
    assign reg_write_out = r_valid && r_reg_write;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a slot-level reference model checked every cycle.
module tb_alu_operand_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] rs1_data, rs2_data, imm;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        reg_write;
    logic [4:0]  exm_rd;
    logic        exm_we;
    logic [31:0] exm_res;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_data;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] A, B, store_data;
    logic [2:0]  ALU_operation;
    logic [4:0]  rd_out;
    logic        reg_write_out;

    int total = 0;
    int bad   = 0;

    alu_operand_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .alu_src(alu_src),
        .alu_op(alu_op), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .reg_write(reg_write), .exm_rd(exm_rd), .exm_we(exm_we), .exm_res(exm_res),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data), .out_ready(out_ready),
        .out_valid(out_valid), .A(A), .B(B), .ALU_operation(ALU_operation),
        .store_data(store_data), .rd_out(rd_out), .reg_write_out(reg_write_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rs1, rs2, imm;
        logic        src;
        logic [2:0]  op;
        logic [4:0]  a1, a2, rd;
        logic        rw;
    } slot_t;

    slot_t m_slot;
    logic  m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Freshest architectural value of a source register as the pipeline would see it.
    function automatic logic [31:0] fresh(input logic [4:0] a, input logic [31:0] held);
`ifdef ALU_OPERAND_FWD_EN
        if (exm_we && a != 0 && exm_rd == a) return exm_res;
        if (wb_we && a != 0 && wb_rd == a) return wb_data;
`endif
        return held;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_slot  <= '{32'h0, 32'h0, 32'h0, 1'b0, 3'b000, 5'h0, 5'h0, 5'h0, 1'b0};
        end else begin
            bit accepts;
            accepts = in_valid && (!m_valid || out_ready) && !flush;
            if (accepts)
                m_slot <= '{rs1_data, rs2_data, imm, alu_src, alu_op, rs1_addr, rs2_addr, rd_addr, reg_write};
            m_valid <= accepts || (m_valid && !out_ready && !flush);
        end
    end

    always @(posedge clk) begin
        #3;
        chk("m_in_ready", {31'b0, in_ready}, {31'b0, !m_valid || out_ready});
        chk("m_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("m_reg_write_out", {31'b0, reg_write_out}, {31'b0, m_valid && m_slot.rw});
        if (m_valid) begin
            logic [31:0] v2;
            v2 = fresh(m_slot.a2, m_slot.rs2);
            chk("m_A", A, fresh(m_slot.a1, m_slot.rs1));
            chk("m_B", B, m_slot.src ? m_slot.imm : v2);
            chk("m_store_data", store_data, v2);
            chk("m_op", {29'b0, ALU_operation}, {29'b0, m_slot.op});
            chk("m_rd_out", {27'b0, rd_out}, {27'b0, m_slot.rd});
        end
    end

    task automatic put(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                       input logic src, input logic [2:0] op, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] rd, input logic rw);
        rs1_data = r1; rs2_data = r2; imm = im; alu_src = src; alu_op = op;
        rs1_addr = a1; rs2_addr = a2; rd_addr = rd; reg_write = rw;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        put(32'h0, 32'h0, 32'h0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0);
        exm_rd = 5'd0; exm_we = 1'b0; exm_res = 32'h0;
        wb_rd = 5'd0; wb_we = 1'b0; wb_data = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_A", A, 32'd0);
        chk("rst_B", B, 32'd0);
        chk("rst_op", {29'b0, ALU_operation}, 32'd0);
        chk("rst_rd_out", {27'b0, rd_out}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;

        // Basic capture with immediate operand.
        put(32'd5, 32'd9, 32'd7, 1'b1, 3'b010, 5'd1, 5'd2, 5'd4, 1'b1);
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("cap_A", A, 32'd5);
        chk("cap_B", B, 32'd7);
        chk("cap_op", {29'b0, ALU_operation}, 32'd2);
        chk("cap_valid", {31'b0, out_valid}, 32'd1);
        chk("cap_store", store_data, 32'd9);
        chk("cap_rd", {27'b0, rd_out}, 32'd4);

        // Register operand B, back-to-back capture.
        put(32'h10, 32'h20, 32'h3, 1'b0, 3'b110, 5'd6, 5'd8, 5'd9, 1'b1);
        @(negedge clk);
        chk("reg_B", B, 32'h20);
        chk("reg_op", {29'b0, ALU_operation}, 32'd6);

        // Stall three cycles with a new slot waiting.
        out_ready = 1'b0;
        put(32'h77, 32'h66, 32'h5, 1'b1, 3'b001, 5'd10, 5'd11, 5'd12, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            chk("stall_A", A, 32'h10);
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("unstall_A", A, 32'h77);
        chk("unstall_B", B, 32'h5);

        // Flush beats an acceptable incoming slot.
        put(32'h88, 32'h99, 32'h1, 1'b0, 3'b011, 5'd1, 5'd1, 5'd2, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_rw", {31'b0, reg_write_out}, 32'd0);
        flush = 1'b0;

        // Forwarding priority on a stalled entry.
        put(32'h1111, 32'h3333, 32'h44, 1'b1, 3'b000, 5'd3, 5'd5, 5'd7, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        exm_we = 1'b1; exm_rd = 5'd3; exm_res = 32'hAAAA;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hBBBB;
        #1;
`ifdef ALU_OPERAND_FWD_EN
        chk("fwd_exm_A", A, 32'hAAAA);
`else
        chk("fwd_exm_A", A, 32'h1111);
`endif
        exm_we = 1'b0;
        #1;
`ifdef ALU_OPERAND_FWD_EN
        chk("fwd_wb_A", A, 32'hBBBB);
`else
        chk("fwd_wb_A", A, 32'h1111);
`endif
        wb_rd = 5'd5;
        #1;
`ifdef ALU_OPERAND_FWD_EN
        chk("fwd_store", store_data, 32'hBBBB);
`else
        chk("fwd_store", store_data, 32'h3333);
`endif
        chk("fwd_B_imm", B, 32'h44);
        @(negedge clk);

        // x0 is never forwarded.
        exm_we = 1'b1; exm_rd = 5'd0; exm_res = 32'hDEAD; wb_we = 1'b0;
        put(32'h2222, 32'h0, 32'h0, 1'b0, 3'b111, 5'd0, 5'd0, 5'd1, 1'b1);
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("x0_A", A, 32'h2222);
        chk("x0_B", B, 32'h0);

        // Mixed traffic; the model compare covers every cycle.
        for (int i = 0; i < 24; i++) begin
            put(32'h100 + i, 32'h200 + 3 * i, 32'h300 ^ i, i[0], i[2:0],
                5'(i % 4), 5'((i + 1) % 4), 5'(i % 8), i[1]);
            in_valid  = (i % 3) != 0;
            out_ready = (i % 4) != 1;
            flush     = (i == 10);
            exm_we = i[0]; exm_rd = 5'((i + 2) % 4); exm_res = 32'hE000 + i;
            wb_we  = 1'b1; wb_rd  = 5'(i % 4);      wb_data = 32'hB000 + i;
            @(negedge clk);
        end
        flush = 1'b0; exm_we = 1'b0; wb_we = 1'b0;

        // Reset in the middle of a stall.
        put(32'h5555, 32'h6666, 32'h7, 1'b0, 3'b101, 5'd2, 5'd3, 5'd4, 1'b1);
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_A", A, 32'd0);
        chk("mid_rst_B", B, 32'd0);
        chk("mid_rst_op", {29'b0, ALU_operation}, 32'd0);
        chk("mid_rst_rw", {31'b0, reg_write_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {31'b0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline register sitting directly upstream of the 32-bit ALU.
- Captures decoded operands, immediate and the 3-bit ALU opcode with a valid/ready handshake.
- Applies stall and flush control.
- Drives the ALU A, B and ALU_operation inputs, with optional EX/MEM and MEM/WB result forwarding.

Parameters:
- XLEN, 32: datapath width; the ALU is fixed at 32, so only 32 is supported.
- REG_AW, 5: register-address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decode slot holds an instruction
- in_ready  out  1  stage accepts the slot this cycle
- flush  in  1  kill the held instruction (branch or exception redirect)
- rs1_data, rs2_data  in  XLEN  register-file read data
- imm  in  XLEN  sign-extended immediate
- alu_src  in  1  1: B = imm, 0: B = rs2 value
- alu_op  in  3  ALU opcode: 000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 sltu
- rs1_addr, rs2_addr, rd_addr  in  REG_AW  source and destination registers
- reg_write  in  1  instruction writes rd
- exm_rd  in  REG_AW  EX/MEM destination register
- exm_we  in  1  EX/MEM writes its destination
- exm_res  in  XLEN  EX/MEM ALU result
- wb_rd  in  REG_AW  MEM/WB destination register
- wb_we  in  1  MEM/WB writes its destination
- wb_data  in  XLEN  MEM/WB write-back value
- out_ready  in  1  EX/MEM stage accepts
- out_valid  out  1  held instruction is valid
- A  out  XLEN  ALU operand A
- B  out  XLEN  ALU operand B
- ALU_operation  out  3  ALU opcode
- store_data  out  XLEN  forwarded rs2 value, for stores
- rd_out  out  REG_AW  destination register
- reg_write_out  out  1  gated by out_valid

Behaviour:
- Reset: all registers clear immediately on rst; out_valid=0, ALU_operation=000, and all data, address and write-enable outputs are 0.
- Single-entry register, latency 1 cycle.
- in_ready = !out_valid || out_ready; purely combinational, no dependence on in_valid.
- Capture: at a clock edge with in_valid && in_ready && !flush, load all fields and set out_valid=1.
- Drain without refill: with out_valid && out_ready and no capture, clear out_valid.
- Stall: with out_valid && !out_ready, all registers hold; outputs remain stable (subject to forwarding).
- Flush:
  - Highest priority: the next-edge out_valid=0 and the incoming slot is discarded even when in_valid && in_ready.
  - Data registers may keep stale contents, but reg_write_out=0 while out_valid=0.
- B selection: B = alu_src_q ? imm_q : rs2_value.
- Forwarding (combinational on the output side):
  - Priority for rsN: exm_we && exm_rd!=0 && exm_rd==rsN_q -> exm_res; else wb_we && wb_rd!=0 && wb_rd==rsN_q -> wb_data; else the registered data.
  - Register x0 is never forwarded.
  - Forwarding stays live during a stall, so a value written back while stalled is picked up.
  - store_data always takes the forwarded rs2 value, regardless of alu_src.
- Hazard control: load-use detection is outside this block and is expressed to it via in_valid/flush.
- Reset mid-stall: drops the held instruction; no partial state survives.

Optional Feature:
- Macro: ALU_OPERAND_FWD_EN.
- Defined: forwarding as specified above.
- Undefined:
  - The exm_* and wb_* inputs are ignored.
  - A = rs1_data_q; the rs2 value = rs2_data_q.
  - The control stalls for RAW hazards upstream.

Decomposition:
- Shared package:
  - ALU opcode constants (ALU_AND=3'b000 through ALU_SLTU=3'b111).
  - XLEN and REG_AW defaults.
  - Forward-select encoding: FWD_NONE=0, FWD_EXM=1, FWD_WB=2.
- One sub-module, alu_fwd_mux: given a source address and the two producer ports, it returns the selected value.
  - Instantiated twice, once for rs1 and once for rs2.
  - Its body is compiled under ALU_OPERAND_FWD_EN.

Test Plan:
- Reset behaviour: assert rst mid-cycle while holding a valid entry -> out_valid=0, A=B=0, and ALU_operation=000 immediately, without waiting for a clock.
- Basic capture: rs1_data=5, imm=7, alu_src=1, alu_op=010, in_valid=1, out_ready=1 -> next cycle A=5, B=7, ALU_operation=010, out_valid=1.
- Stall: out_ready=0 for 3 cycles with new in_valid data -> in_ready=0, outputs unchanged; the new slot is accepted on the first cycle with out_ready=1.
- Flush priority: flush=1 together with in_valid=1 -> next cycle out_valid=0 and reg_write_out=0.
- Forward priority: rs1_addr=3 with exm_rd=3 (exm_res=0xAAAA) and wb_rd=3 (wb_data=0xBBBB) -> A=0xAAAA; with exm_we=0 -> A=0xBBBB.
- x0 and macro-off: rs1_addr=0 and exm_rd=0 with exm_we=1 -> A=rs1_data_q; with the macro undefined, exm_rd=3 matches -> A=rs1_data_q.
